// File: rtl/smp_bus_pkg.sv
// Shared types and defaults for the SMP bus arbiter.
// The helper picks the lowest set bit of a request/hit vector as a one-hot.
package smp_bus_pkg;
  localparam int MAX_CPUS     = 8;
  localparam int NUM_CPUS_DEF = 4;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [2:0] {IDLE, GRANT, SNOOP, MEM, DONE} state_t;

  function automatic logic [MAX_CPUS-1:0] lowest_onehot(input logic [MAX_CPUS-1:0] v);
    return v & (~v + MAX_CPUS'(1));
  endfunction
endpackage

// File: rtl/smp_bus_arbiter_rr.sv
// Combinational round-robin selector: search starts just after the last winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int c;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(last) + i) % N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/smp_bus_arbiter.sv
// Shared-bus responder: round-robin grant, snoop broadcast, memory completion.
// Define SMP_BUS_INTERVENTION_EN to let a snooping cache supply read data.
module smp_bus_arbiter
  import smp_bus_pkg::*;
#(
  parameter int NUM_CPUS = NUM_CPUS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CPUS-1:0]        bus_request,
  output logic [NUM_CPUS-1:0]        bus_grant,
  input  logic [NUM_CPUS*ADDR_W-1:0] m_addr,
  input  logic [NUM_CPUS-1:0]        m_rw,
  input  logic [NUM_CPUS*DATA_W-1:0] m_data,
  input  logic [NUM_CPUS-1:0]        snoop_hit,
  output logic                       bus_valid,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic                       bus_rw,
  output logic                       invalidate,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_done,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ack
);
  localparam int IW = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  state_t              state;
  logic [IW-1:0]       last_win, cur_idx, arb_idx;
  logic [NUM_CPUS-1:0] arb_gnt;
  logic                tx_rw;
  logic [ADDR_W-1:0]   tx_addr;
  logic [DATA_W-1:0]   tx_data;
  logic                ivn;
  logic [DATA_W-1:0]   ivn_data;

  rr_arbiter #(.N(NUM_CPUS), .IW(IW)) u_arb (
    .req (bus_request),
    .last(last_win),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef SMP_BUS_INTERVENTION_EN
  logic [NUM_CPUS-1:0]        eff_hit;
  logic [MAX_CPUS-1:0]        hit_oh;
  logic [MAX_CPUS*DATA_W-1:0] data_pad;

  // The master's own hit is meaningless: it is the one missing.
  assign eff_hit  = snoop_hit & ~bus_grant;
  assign hit_oh   = lowest_onehot(MAX_CPUS'(eff_hit));
  assign data_pad = (MAX_CPUS*DATA_W)'(m_data);
  assign ivn      = !tx_rw && (|eff_hit);

  always_comb begin
    ivn_data = '0;
    for (int i = 0; i < MAX_CPUS; i++)
      if (hit_oh[i]) ivn_data = ivn_data | data_pad[i*DATA_W +: DATA_W];
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^snoop_hit;
  assign ivn          = 1'b0;
  assign ivn_data     = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_win   <= IW'(NUM_CPUS-1);
      cur_idx    <= '0;
      tx_rw      <= 1'b0;
      tx_addr    <= '0;
      tx_data    <= '0;
      bus_grant  <= '0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      bus_rw     <= 1'b0;
      invalidate <= 1'b0;
      bus_data   <= '0;
      bus_done   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (|bus_request) begin
          bus_grant <= arb_gnt;
          cur_idx   <= arb_idx;
          state     <= GRANT;
        end
        GRANT: begin
          tx_addr    <= m_addr[cur_idx*ADDR_W +: ADDR_W];
          tx_data    <= m_data[cur_idx*DATA_W +: DATA_W];
          tx_rw      <= m_rw[cur_idx];
          bus_valid  <= 1'b1;
          bus_addr   <= m_addr[cur_idx*ADDR_W +: ADDR_W];
          bus_rw     <= m_rw[cur_idx];
          invalidate <= m_rw[cur_idx];
          state      <= SNOOP;
        end
        SNOOP: begin
          bus_valid  <= 1'b0;
          bus_addr   <= '0;
          bus_rw     <= 1'b0;
          invalidate <= 1'b0;
          if (ivn) begin
            bus_data <= ivn_data;
            bus_done <= 1'b1;
            state    <= DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= tx_rw;
            mem_addr  <= tx_addr;
            mem_wdata <= tx_data;
            state     <= MEM;
          end
        end
        MEM: if (mem_ack) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (!tx_rw) bus_data <= mem_rdata;
          bus_done  <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          bus_done  <= 1'b0;
          bus_grant <= '0;
          last_win  <= cur_idx;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_smp_bus_arbiter.sv
// Randomized bench for smp_bus_arbiter against a transaction-level reference model.
// Follows SMP_BUS_INTERVENTION_EN for the expected read-completion path.
module tb_smp_bus_arbiter;
  localparam int N = 4;

  logic          clk, reset;
  logic [N-1:0]  bus_request, bus_grant, m_rw, snoop_hit;
  logic [N*32-1:0] m_addr, m_data;
  logic          bus_valid, bus_rw, invalidate, bus_done, mem_req, mem_we, mem_ack;
  logic [31:0]   bus_addr, bus_data, mem_addr, mem_wdata, mem_rdata;

  smp_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .bus_request(bus_request), .bus_grant(bus_grant),
    .m_addr(m_addr), .m_rw(m_rw), .m_data(m_data), .snoop_hit(snoop_hit),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .invalidate(invalidate), .bus_data(bus_data), .bus_done(bus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          last_w;        // model: previous winner
  logic [31:0] exp_bd;        // model: bus_data
  logic [31:0] ma [N];
  logic [31:0] md [N];
  logic        mr [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("grant_onehot0", 64'($onehot0(bus_grant)), 64'd1);
  endtask

  task automatic drive_m();
    for (int i = 0; i < N; i++) begin
      m_addr[i*32 +: 32] = ma[i];
      m_data[i*32 +: 32] = md[i];
      m_rw[i]            = mr[i];
    end
  endtask

  task automatic randomize_caches();
    for (int i = 0; i < N; i++) begin
      ma[i] = $urandom;
      md[i] = $urandom;
      mr[i] = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'(bus_grant) | 64'(bus_valid) | 64'(bus_addr) | 64'(bus_rw) |
           64'(invalidate) | 64'(bus_data) | 64'(bus_done) | 64'(mem_req) |
           64'(mem_we) | 64'(mem_addr) | 64'(mem_wdata);
  endfunction

  // One full transaction; entered and left at a negedge in an idle cycle.
  task automatic run_txn(input logic [N-1:0] req, input int k, input logic [N-1:0] hits,
                         input logic [31:0] rdata, input bit drop);
    int          w;
    logic [N-1:0] g;
    logic [31:0] ea, ed, ivd;
    logic        erw;
    bit          ivn;
    w = -1;
    for (int j = 1; j <= N; j++)
      if (w < 0 && req[(last_w + j) % N]) w = (last_w + j) % N;
    g   = '0;
    g[w] = 1'b1;
    ea  = ma[w];
    ed  = md[w];
    erw = mr[w];
    ivn = 0;
    ivd = '0;
`ifdef SMP_BUS_INTERVENTION_EN
    if (!erw)
      for (int j = N-1; j >= 0; j--)
        if (hits[j] && j != w) begin
          ivn = 1;
          ivd = md[j];
        end
`endif
    // cycle 0
    bus_request = req;
    snoop_hit   = hits;
    mem_ack     = 1'($urandom_range(0, 1));
    drive_m();
    chk("idle_grant", 64'(bus_grant), 64'd0);
    step(); // cycle 1
    chk("grant", 64'(bus_grant), 64'(g));
    chk("valid_c1", 64'(bus_valid), 64'd0);
    mem_ack = 1'($urandom_range(0, 1));
    if (drop) bus_request[w] = 1'b0;
    step(); // cycle 2: snoop broadcast
    chk("bus_valid", 64'(bus_valid), 64'd1);
    chk("bus_addr", 64'(bus_addr), 64'(ea));
    chk("bus_rw", 64'(bus_rw), 64'(erw));
    chk("invalidate", 64'(invalidate), 64'(erw));
    chk("mem_req_c2", 64'(mem_req), 64'd0);
    ma[w] = $urandom;
    md[w] = $urandom;
    mr[w] = ~mr[w];
    drive_m();
    mem_ack = 1'($urandom_range(0, 1));
    step(); // cycle 3
    chk("valid_c3", 64'(bus_valid), 64'd0);
    if (ivn) begin
      mem_ack = 1'b0;
      exp_bd  = ivd;
      chk("ivn_done", 64'(bus_done), 64'd1);
      chk("ivn_mem_req", 64'(mem_req), 64'd0);
    end else begin
      chk("mem_req", 64'(mem_req), 64'd1);
      chk("mem_we", 64'(mem_we), 64'(erw));
      chk("mem_addr", 64'(mem_addr), 64'(ea));
      chk("mem_wdata", 64'(mem_wdata), 64'(ed));
      for (int i = 0; i < k; i++) begin
        mem_ack = 1'b0;
        step();
        chk("mem_hold", {mem_req, mem_we, bus_done, mem_addr, 29'(mem_wdata)},
            {1'b1, erw, 1'b0, ea, 29'(ed)});
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      step(); // cycle 4+k
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!erw) exp_bd = rdata;
      chk("done", 64'(bus_done), 64'd1);
      chk("mem_req_done", 64'(mem_req), 64'd0);
    end
    chk("bus_data", 64'(bus_data), 64'(exp_bd));
    chk("grant_done", 64'(bus_grant), 64'(g));
    bus_request = '0;
    step(); // idle after done
    chk("grant_clear", 64'(bus_grant), 64'd0);
    chk("done_pulse", 64'(bus_done), 64'd0);
    last_w    = w;
    snoop_hit = '0;
  endtask

  initial begin
    reset = 1'b0; bus_request = '0; snoop_hit = '0; mem_ack = 1'b0; mem_rdata = '0;
    m_addr = '0; m_data = '0; m_rw = '0;
    last_w = N-1; exp_bd = '0;
    randomize_caches();
    step();
    step();
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b1;
    step();

    // Fairness: everyone requests, expect 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      randomize_caches();
      run_txn(4'hF, $urandom_range(0, 2), '0, $urandom, 0);
    end

    // Single read from cache 1, two wait cycles
    randomize_caches();
    ma[1] = 32'h100; mr[1] = 1'b0;
    run_txn(4'b0010, 2, '0, 32'hDEADBEEF, 0);

    // Write invalidate from cache 0
    randomize_caches();
    ma[0] = 32'h40; md[0] = 32'h55AA; mr[0] = 1'b1;
    run_txn(4'b0001, 3, '0, $urandom, 0);

    // Read from cache 2 with snoopers 0 and 3 hitting
    randomize_caches();
    ma[2] = 32'h80; mr[2] = 1'b0; md[0] = 32'h1234;
    run_txn(4'b0100, 1, 4'b1001, 32'hCAFEF00D, 0);

    // Reset while a memory access is outstanding
    randomize_caches();
    mr[2] = 1'b0;
    bus_request = 4'b0100;
    drive_m();
    step(); step(); step();
    chk("mem_req_pre_reset", 64'(mem_req), 64'd1);
    reset = 1'b0;
    step();
    chk("reset_mid_outs", all_outs(), 64'd0);
    reset = 1'b1;
    bus_request = '0;
    last_w = N-1;
    exp_bd = '0;
    randomize_caches();
    run_txn(4'b1001, 0, '0, $urandom, 0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          mem_ack = 1'($urandom_range(0, 1));
          step();
          chk("gap_grant", 64'(bus_grant), 64'd0);
        end
      end
      randomize_caches();
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 4), 4'($urandom_range(0, 15)),
              $urandom, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
